// File: rtl/wave_gen_if.sv
// Stream and control bundle for the wave_gen waveform generator.
// The master side supplies waveform settings and back-pressure and consumes
// samples. The slave side (the generator) produces the samples.
interface wave_gen_if #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 16
);
    logic                     enable_i;
    logic [phase_width_p-1:0] incr_i;
    logic [1:0]               mode_i;
    logic [width_p-1:0]       duty_i;
    logic [width_p-1:0]       amp_i;
    logic                     ready_i;
    logic [width_p-1:0]       data_o;
    logic                     valid_o;
    logic                     sop_o;

    modport master (
        output enable_i, incr_i, mode_i, duty_i, amp_i, ready_i,
        input  data_o, valid_o, sop_o
    );

    modport slave (
        input  enable_i, incr_i, mode_i, duty_i, amp_i, ready_i,
        output data_o, valid_o, sop_o
    );
endinterface

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator with a valid/ready output stream.
// Each accepted slot produces one amplitude-scaled sample from the current
// phase, then advances the phase. Waveform changes are held back until the
// phase wraps, so a period is never a mix of two shapes.
module wave_gen #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    wave_gen_if.slave    bus
);
    typedef enum logic [1:0] {
        SAW_UP = 2'd0,
        SAW_DN = 2'd1,
        TRI    = 2'd2,
        SQUARE = 2'd3
    } mode_t;

    // The triangle reads the slice just below the MSB, so the accumulator
    // needs at least one bit more than the sample.
    generate
        if (phase_width_p < width_p + 1) begin : g_bad_width
            $error("wave_gen: phase_width_p must be >= width_p+1");
        end
    endgenerate

    logic [phase_width_p-1:0] r_phase;
    mode_t                    r_mode;
    logic                     r_wrap;
    logic [width_p-1:0]       r_data;
    logic                     r_sop;
    logic                     r_valid;

    logic                     w_load;
    logic [phase_width_p:0]   w_sum;
    logic                     w_carry;
    logic [width_p-1:0]       w_u;
    logic [width_p-1:0]       w_t;
    logic                     w_msb;
    logic [width_p-1:0]       w_f;
    logic [width_p:0]         w_amp_plus1;
    logic [width_p-1:0]       w_scaled;

    // A new sample may be produced when the output slot is empty or is being
    // drained this cycle.
    assign w_load  = bus.enable_i && (!r_valid || bus.ready_i);

    // Extra top bit of the sum is the period-wrap carry.
    assign w_sum   = {1'b0, r_phase} + {1'b0, bus.incr_i};
    assign w_carry = w_sum[phase_width_p];

    assign w_u   = r_phase[phase_width_p-1 -: width_p];
    assign w_t   = r_phase[phase_width_p-2 -: width_p];
    assign w_msb = r_phase[phase_width_p-1];

    // Unscaled waveform value for the current phase and latched mode.
    always_comb begin
        w_f = '0;
        unique case (r_mode)
            SAW_UP: w_f = w_u;
            SAW_DN: w_f = ~w_u;
            TRI:    w_f = w_msb ? ~w_t : w_t;
            SQUARE: w_f = (w_u < bus.duty_i) ? '1 : '0;
            default: w_f = '0;
        endcase
    end

    // amp+1 lets amp = full scale pass f through unchanged after the shift.
    assign w_amp_plus1 = {1'b0, bus.amp_i} + (width_p+1)'(1);
    assign w_scaled    = width_p'(({{width_p{1'b0}}, w_f} *
                                   {{(width_p-1){1'b0}}, w_amp_plus1}) >> width_p);

    // Output slot, phase accumulator and wrap flag; a held sample never moves.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_phase <= '0;
            r_wrap  <= 1'b1;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_scaled;
            r_sop   <= r_wrap;
            r_valid <= 1'b1;
            r_phase <= w_sum[phase_width_p-1:0];
            r_wrap  <= w_carry;
        end else if (r_valid && bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Mode is adopted only at a period boundary or while generation is idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mode <= mode_t'(bus.mode_i);
        end else if ((w_load && w_carry) || !bus.enable_i) begin
            r_mode <= mode_t'(bus.mode_i);
        end
    end

    assign bus.data_o  = r_data;
    assign bus.sop_o   = r_sop;
    assign bus.valid_o = r_valid;
endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_wave_gen;
    localparam int W    = 12;
    localparam int PW   = 16;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    wave_gen_if #(.width_p(W), .phase_width_p(PW)) wif ();

    wave_gen #(.width_p(W), .phase_width_p(PW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (wif.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: phase as a plain integer in [0, 2^PW).
    int m_phase;
    int m_mode;
    int m_data;
    bit m_wrap;
    bit m_sop;
    bit m_valid;

    function automatic int wave(int mode, int phase, int duty);
        int u, t, max_v;
        bit upper_half;
        u          = phase / (1 << (PW - W));
        t          = (phase / (1 << (PW - W - 1))) % (1 << W);
        upper_half = (phase >= (1 << (PW - 1)));
        max_v      = MAXV;
        case (mode)
            0: return u;
            1: return max_v - u;
            2: return upper_half ? (max_v - t) : t;
            default: return (u < duty) ? max_v : 0;
        endcase
    endfunction

    // Applies one clock edge worth of behaviour using the inputs seen at that edge.
    task automatic model_edge();
        int sum;
        bit ld;
        if (rst) begin
            m_phase = 0;
            m_mode  = int'(wif.mode_i);
            m_wrap  = 1'b1;
            m_data  = 0;
            m_sop   = 1'b0;
            m_valid = 1'b0;
        end else begin
            ld = wif.enable_i && (!m_valid || wif.ready_i);
            if (ld) begin
                m_data  = (wave(m_mode, m_phase, int'(wif.duty_i)) * (int'(wif.amp_i) + 1)) / (1 << W);
                m_sop   = m_wrap;
                m_valid = 1'b1;
                sum     = m_phase + int'(wif.incr_i);
                m_wrap  = (sum >= (1 << PW));
                if (m_wrap) m_mode = int'(wif.mode_i);
                m_phase = sum % (1 << PW);
            end else if (m_valid && wif.ready_i) begin
                m_valid = 1'b0;
            end
            if (!wif.enable_i) m_mode = int'(wif.mode_i);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_valid", 32'(wif.valid_o), 32'(m_valid));
        check("model_data",  32'(wif.data_o),  32'(m_data));
        check("model_sop",   32'(wif.sop_o),   32'(m_sop));
    endtask

    task automatic cfg(input int mode, input int incr, input int duty, input int amp);
        wif.mode_i = 2'(mode);
        wif.incr_i = PW'(incr);
        wif.duty_i = W'(duty);
        wif.amp_i  = W'(amp);
    endtask

    initial begin
        int exp_v;
        int prev_obs;
        bit found;
        int r;

        rst = 1'b1;
        wif.enable_i = 1'b1;
        wif.ready_i  = 1'b1;
        cfg(0, 16, 0, MAXV);
        repeat (3) step();
        check("reset_valid", 32'(wif.valid_o), 0);
        check("reset_data",  32'(wif.data_o),  0);
        check("reset_sop",   32'(wif.sop_o),   0);

        // Rising sawtooth, one code per sample, wraps after 4096 samples.
        rst = 1'b0;
        for (int k = 0; k < 4098; k++) begin
            step();
            check("saw_data", 32'(wif.data_o), 32'(k % 4096));
            check("saw_sop",  32'(wif.sop_o),  32'((k % 4096) == 0));
        end

        // Triangle, 8192 samples per period.
        cfg(2, 8, 0, MAXV);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8193; k++) begin
            step();
            r = k % 8192;
            exp_v = (r < 4096) ? r : (8191 - r);
            check("tri_data", 32'(wif.data_o), 32'(exp_v));
            check("tri_sop",  32'(wif.sop_o),  32'(r == 0));
        end

        // Back-pressure: the held sample stays put, then the ramp resumes.
        cfg(0, 16, 0, MAXV);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        wif.ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_data",  32'(wif.data_o),  9);
            check("stall_valid", 32'(wif.valid_o), 1);
            check("stall_sop",   32'(wif.sop_o),   0);
        end
        wif.ready_i = 1'b1;
        step();
        check("resume_data0", 32'(wif.data_o), 10);
        step();
        check("resume_data1", 32'(wif.data_o), 11);

        // Mode switch mid-period is deferred to the next period boundary.
        repeat (1990) step();
        cfg(3, 16, 2048, MAXV);
        found = 1'b0;
        prev_obs = 0;
        for (int k = 0; k < 5000 && !found; k++) begin
            prev_obs = int'(wif.data_o);
            step();
            if (wif.sop_o) found = 1'b1;
        end
        check("square_sop_seen", 32'(found), 1);
        check("saw_end_value", 32'(prev_obs), 32'(MAXV));
        for (int j = 0; j < 4096; j++) begin
            if (j != 0) step();
            check("square_data", 32'(wif.data_o), (j < 2048) ? 32'(MAXV) : 32'd0);
        end

        // Amplitude scaling: half scale and zero scale.
        cfg(0, 65520, 0, 2047);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("amp_first", 32'(wif.data_o), 0);
        step();
        check("amp_half_full", 32'(wif.data_o), 2047);
        wif.amp_i = '0;
        step();
        check("amp_zero", 32'(wif.data_o), 0);

        // Reset during a stalled stream drops the pending sample.
        wif.amp_i   = W'(MAXV);
        wif.ready_i = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midrst_valid", 32'(wif.valid_o), 0);
        check("midrst_data",  32'(wif.data_o),  0);
        rst = 1'b0;
        step();
        check("postrst_valid", 32'(wif.valid_o), 1);
        check("postrst_data",  32'(wif.data_o),  0);
        check("postrst_sop",   32'(wif.sop_o),   1);
        wif.ready_i = 1'b1;

        // Square duty extremes: zero duty is always low, full duty drops only at u=max.
        cfg(3, 4096, 0, MAXV);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("duty0_data", 32'(wif.data_o), 0);
        end
        cfg(3, 65520, MAXV, MAXV);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("dutymax_u0", 32'(wif.data_o), 32'(MAXV));
        step();
        check("dutymax_umax", 32'(wif.data_o), 0);
        step();
        check("dutymax_u4094", 32'(wif.data_o), 32'(MAXV));

        // Randomized traffic, including incr=0, duty/amp extremes and sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            wif.enable_i = ($urandom_range(0, 7) != 0);
            wif.ready_i  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                wif.mode_i = 2'($urandom_range(0, 3));
                r = $urandom_range(0, 3);
                wif.incr_i = (r == 0) ? '0 : (r == 1) ? PW'($urandom_range(1, 64)) : PW'($urandom);
                r = $urandom_range(0, 2);
                wif.duty_i = (r == 0) ? '0 : (r == 1) ? W'(MAXV) : W'($urandom);
                r = $urandom_range(0, 2);
                wif.amp_i  = (r == 0) ? '0 : (r == 1) ? W'(MAXV) : W'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter: width_p, 12, sample width in bits (unsigned, full scale 2^width_p-1).
REQ-002 Parameter: phase_width_p, 16, phase accumulator width; SHALL be >= width_p+1 (elaboration error otherwise).
REQ-003 clk_i  input  1  sole clock; all state on posedge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 enable_i  input  1  permits generation of new samples.
REQ-006 incr_i  input  phase_width_p  phase increment per produced sample.
REQ-007 mode_i  input  2  waveform select: 0 SAW_UP, 1 SAW_DN, 2 TRI, 3 SQUARE.
REQ-008 duty_i  input  width_p  SQUARE high threshold.
REQ-009 amp_i  input  width_p  amplitude scale.
REQ-010 data_o  output  width_p  sample, registered.
REQ-011 valid_o  output  1  data_o holds a sample.
REQ-012 ready_i  input  1  downstream accepts sample when valid_o && ready_i.
REQ-013 sop_o  output  1  start-of-period flag qualifying data_o.

Function
REQ-014 Internal state: phase_r (phase_width_p), mode_r (2), wrap_r (1), plus output registers.
REQ-015 Load condition: load = enable_i && (!valid_o || ready_i).
REQ-016 On load: data_o <= scaled f(mode_r, phase_r); sop_o <= wrap_r; valid_o <= 1; phase_r <= phase_r + incr_i modulo 2^phase_width_p.
REQ-017 No load and valid_o && ready_i: valid_o <= 0; data_o and sop_o hold.
REQ-018 valid_o && !ready_i: data_o, sop_o, valid_o, phase_r all hold (no sample lost or skipped).
REQ-019 Latency: sample from phase_r appears on data_o the cycle after load; max throughput one sample per cycle with ready_i held high.
REQ-020 wrap_r on load <= carry-out of phase_r + incr_i; incr_i = 0 never wraps.
REQ-021 mode_r <= mode_i only on a load with carry-out, or on any cycle with enable_i low; mode change mid-period SHALL be deferred to the period boundary.
REQ-022 Let u = phase_r[phase_width_p-1 -: width_p], t = phase_r[phase_width_p-2 -: width_p], m = phase_r[phase_width_p-1].
REQ-023 SAW_UP f = u; SAW_DN f = ~u; TRI f = m ? ~t : t; SQUARE f = (u < duty_i) ? 2^width_p-1 : 0.
REQ-024 SQUARE duty_i = 0 SHALL give constant 0; duty_i = 2^width_p-1 high on all but u = max.
REQ-025 Scaling: data_o = (f * (amp_i+1)) >> width_p, full-precision product, truncated; amp_i = max SHALL give data_o = f exactly.
REQ-026 duty_i, amp_i, incr_i sampled at load, take effect immediately (not deferred).

Reset
REQ-027 When reset_i is high at a clock edge: phase_r = 0, mode_r = mode_i, wrap_r = 1, data_o = 0, sop_o = 0, valid_o = 0; reset overrides load and handshake.
REQ-028 Reset mid-stream SHALL discard any pending unaccepted sample; first sample after reset has phase 0 and sop_o = 1.

Verification
REQ-029 SAW_UP, incr_i=16, amp_i=4095, ready_i=1, enable_i=1 (defaults) -> data_o 0,1,2,...,4095,0; sop_o=1 on 1st and 4097th samples only.
REQ-030 TRI, incr_i=8, amp=4095 -> 0..4095 rising, then 4095,4094..0; 8192 samples/period; sop_o once per period.
REQ-031 Backpressure: ready_i low 5 cycles while valid_o=1 -> data_o/sop_o stable, on release sequence continues with no gap or repeat.
REQ-032 Mode switch SAW_UP->SQUARE (duty_i=2048) at mid-period -> saw continues to 4095, SQUARE starts at next sop_o: 2048 samples of 4095 then 2048 of 0.
REQ-033 amp_i=2047, SAW_UP sample f=4095 -> data_o=2047; amp_i=0 -> data_o=0 for f<4096.
REQ-034 Assert reset_i 1 cycle during active stream with ready_i low -> next cycle valid_o=0, data_o=0; then first sample 0 with sop_o=1.
